// File: rtl/axi_rd_master_pkg.sv
// Types and fixed AXI encodings shared by the AXI read master and its helpers.
`include "AXI_define.svh"

package axi_rd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    localparam logic [`AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [`AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
    localparam logic [`AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

    // Bursts are always word sized, so the byte offset is simply dropped.
    function automatic logic [`AXI_ADDR_BITS-1:0] word_align(input logic [`AXI_ADDR_BITS-1:0] addr);
        return addr & ~`AXI_ADDR_BITS'(3);
    endfunction

endpackage

// File: rtl/axi_rd_master_if.sv
// AXI read-address and read-data channels bundled for the read master.
`include "AXI_define.svh"

interface axi_rd_master_if;

    logic [`AXI_ID_BITS-1:0]    ARID;
    logic [`AXI_ADDR_BITS-1:0]  ARADDR;
    logic [`AXI_LEN_BITS-1:0]   ARLEN;
    logic [`AXI_SIZE_BITS-1:0]  ARSIZE;
    logic [`AXI_BURST_BITS-1:0] ARBURST;
    logic                       ARVALID;
    logic                       ARREADY;

    logic [`AXI_ID_BITS-1:0]    RID;
    logic [`AXI_DATA_BITS-1:0]  RDATA;
    logic [`AXI_RESP_BITS-1:0]  RRESP;
    logic                       RLAST;
    logic                       RVALID;
    logic                       RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/AXI_define.svh
// Shared AXI field widths used by every block that talks to the AXI fabric.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH

`define AXI_ID_BITS    4
`define AXI_ADDR_BITS  32
`define AXI_DATA_BITS  32
`define AXI_LEN_BITS   4
`define AXI_SIZE_BITS  3
`define AXI_BURST_BITS 2
`define AXI_RESP_BITS  2

`endif

// File: rtl/axi_rd_master_beat_counter.sv
// Beat counter for one read burst; flags an RLAST that arrives at the wrong count.
`include "AXI_define.svh"

module rd_beat_counter
    import axi_rd_master_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     inc,
    input  logic                     last,
    input  logic [`AXI_LEN_BITS-1:0] len,
    output logic                     len_mismatch
);

    logic [`AXI_LEN_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count still holds the index of the beat being presented, which must equal len on RLAST.
    assign len_mismatch = last && (cnt_q != len);

endmodule

// File: rtl/axi_rd_master.sv
// Single-outstanding AXI4 INCR read master driven by a simple CPU request port.
// Optional sticky response/length checking is enabled by defining AXI_RD_MASTER_ERR_EN.
`include "AXI_define.svh"

module axi_rd_master
    import axi_rd_master_pkg::*;
#(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic [`AXI_ADDR_BITS-1:0] cpu_addr,
    input  logic [`AXI_LEN_BITS-1:0]  cpu_len,
    output logic                      cpu_ready,
    output logic [`AXI_DATA_BITS-1:0] cpu_rdata,
    output logic                      cpu_rvalid,
    output logic                      cpu_done,
    output logic                      cpu_err,
    input  logic                      cpu_err_clr,
    axi_rd_master_if.master           axi
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ADDR = ST_ADDR;
    localparam logic [1:0] DATA = ST_DATA;

    logic [1:0]                state_q, state_d;
    logic [`AXI_ADDR_BITS-1:0] addr_q, addr_d;
    logic [`AXI_LEN_BITS-1:0]  len_q, len_d;
    logic [`AXI_DATA_BITS-1:0] rdata_q, rdata_d;
    logic                      rvalid_q, rvalid_d;
    logic                      done_q, done_d;
    logic                      cnt_clear;
    logic                      beat_ok;
    logic                      len_mismatch;

    // Beats tagged for another master are drained but otherwise invisible to this block.
    assign beat_ok = (state_q == DATA) && axi.RVALID && (axi.RID == MASTER_ID);

    // The done cycle is still busy so a held request cannot slip in right behind a burst.
    assign cpu_ready = (state_q == IDLE) && !done_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        done_d    = 1'b0;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req && cpu_ready) begin
                    addr_d  = word_align(cpu_addr);
                    len_d   = cpu_len;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (axi.ARREADY) begin
                    cnt_clear = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (beat_ok) begin
                    rdata_d  = axi.RDATA;
                    rvalid_d = 1'b1;
                    if (axi.RLAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
        end
    end

    rd_beat_counter u_beat_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clear),
        .inc          (beat_ok),
        .last         (axi.RLAST),
        .len          (len_q),
        .len_mismatch (len_mismatch)
    );

    assign axi.ARID    = MASTER_ID;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = len_q;
    assign axi.ARSIZE  = SIZE_WORD;
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARVALID = (state_q == ADDR);
    assign axi.RREADY  = (state_q == DATA);

    assign cpu_rdata  = rdata_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_done   = done_q;

`ifdef AXI_RD_MASTER_ERR_EN
    logic err_q, err_d;

    // A new error outranks a clear arriving in the same cycle.
    always_comb begin
        err_d = err_q;
        if (cpu_err_clr) begin
            err_d = 1'b0;
        end
        if (beat_ok && ((axi.RRESP != RESP_OKAY) || len_mismatch)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cpu_err = err_q;
`else
    logic unused_err_inputs;

    assign cpu_err           = 1'b0;
    assign unused_err_inputs = &{1'b0, cpu_err_clr, axi.RRESP, len_mismatch};
`endif

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed self-checking bench for axi_rd_master with a hand-driven AXI slave.
module tb_axi_rd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_len;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_err_clr;

    int checks   = 0;
    int failures = 0;

    axi_rd_master_if axi_bus();

    axi_rd_master #(.MASTER_ID(4'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_len     (cpu_len),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_done    (cpu_done),
        .cpu_err     (cpu_err),
        .cpu_err_clr (cpu_err_clr),
        .axi         (axi_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic slave_idle();
        axi_bus.ARREADY = 1'b0;
        axi_bus.RVALID  = 1'b0;
        axi_bus.RLAST   = 1'b0;
        axi_bus.RID     = 4'd0;
        axi_bus.RRESP   = 2'b00;
        axi_bus.RDATA   = 32'h0;
    endtask

    // Leaves the bench at the first negedge with the DUT in its address phase.
    task automatic issue_req(input logic [31:0] addr, input logic [3:0] len);
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        cpu_len  = len;
        @(negedge clk);
        cpu_req  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = 32'h0;
        cpu_len = 4'd0;
        cpu_err_clr = 1'b0;
        slave_idle();
        repeat (3) @(negedge clk);
        checks++; if (axi_bus.ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_arvalid: got %b want 0", axi_bus.ARVALID); end
        checks++; if (axi_bus.RREADY !== 1'b0) begin failures++; $display("[TB] FAIL reset_rready: got %b want 0", axi_bus.RREADY); end
        checks++; if (cpu_rvalid !== 1'b0 || cpu_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulses: got rvalid=%b done=%b want 0/0", cpu_rvalid, cpu_done); end
        checks++; if (cpu_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b want 0", cpu_err); end
        checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h want 0", cpu_rdata); end
        checks++; if (axi_bus.ARADDR !== 32'h0 || axi_bus.ARLEN !== 4'd0) begin failures++; $display("[TB] FAIL reset_ar_payload: got %h/%0d want 0/0", axi_bus.ARADDR, axi_bus.ARLEN); end
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b want 1", cpu_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        axi_bus.ARREADY = 1'b1;
        axi_bus.RVALID  = 1'b1;
        axi_bus.RDATA   = 32'hDEADBEEF;
        axi_bus.RLAST   = 1'b1;
        issue_req(32'h0000_1004, 4'd0);
        checks++; if (axi_bus.ARVALID !== 1'b1 || cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_addr_phase: got arvalid=%b ready=%b want 1/0", axi_bus.ARVALID, cpu_ready); end
        checks++; if (axi_bus.ARADDR !== 32'h0000_1004 || axi_bus.ARLEN !== 4'd0) begin failures++; $display("[TB] FAIL single_ar_payload: got %h/%0d want 00001004/0", axi_bus.ARADDR, axi_bus.ARLEN); end
        checks++; if (axi_bus.ARID !== 4'd0 || axi_bus.ARSIZE !== 3'b010 || axi_bus.ARBURST !== 2'b01) begin failures++; $display("[TB] FAIL single_ar_fixed: got id=%0d size=%b burst=%b want 0/010/01", axi_bus.ARID, axi_bus.ARSIZE, axi_bus.ARBURST); end
        @(negedge clk);
        checks++; if (axi_bus.RREADY !== 1'b1 || axi_bus.ARVALID !== 1'b0 || cpu_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL single_data_phase: got rready=%b arvalid=%b rvalid=%b want 1/0/0", axi_bus.RREADY, axi_bus.ARVALID, cpu_rvalid); end
        @(negedge clk);
        slave_idle();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_done !== 1'b1) begin failures++; $display("[TB] FAIL single_done: got rvalid=%b done=%b want 1/1", cpu_rvalid, cpu_done); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_rdata: got %h want deadbeef", cpu_rdata); end
        checks++; if (cpu_ready !== 1'b0 || axi_bus.RREADY !== 1'b0) begin failures++; $display("[TB] FAIL single_done_cycle_busy: got ready=%b rready=%b want 0/0", cpu_ready, axi_bus.RREADY); end
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0 || cpu_done !== 1'b0 || cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_after: got rvalid=%b done=%b ready=%b want 0/0/1", cpu_rvalid, cpu_done, cpu_ready); end
    endtask

    task automatic test_ar_stall();
        logic [31:0] exp_data;
        logic        exp_done;
        slave_idle();
        issue_req(32'h0000_2002, 4'd3);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (axi_bus.ARVALID !== 1'b1 || axi_bus.ARADDR !== 32'h0000_2000 || axi_bus.ARLEN !== 4'd3) begin
                failures++;
                $display("[TB] FAIL stall_payload_%0d: got v=%b a=%h l=%0d want 1/00002000/3", c, axi_bus.ARVALID, axi_bus.ARADDR, axi_bus.ARLEN);
            end
            if (c < 4) @(negedge clk);
        end
        axi_bus.ARREADY = 1'b1;
        @(negedge clk);
        axi_bus.ARREADY = 1'b0;
        checks++; if (axi_bus.ARVALID !== 1'b0 || axi_bus.RREADY !== 1'b1) begin failures++; $display("[TB] FAIL stall_handshake: got arvalid=%b rready=%b want 0/1", axi_bus.ARVALID, axi_bus.RREADY); end
        axi_bus.RVALID = 1'b1;
        axi_bus.RDATA  = 32'h10;
        axi_bus.RLAST  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_data = 32'h10 + 32'(i);
            exp_done = (i == 3);
            checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_data) begin failures++; $display("[TB] FAIL stall_beat_%0d: got v=%b d=%h want 1/%h", i, cpu_rvalid, cpu_rdata, exp_data); end
            checks++; if (cpu_done !== exp_done) begin failures++; $display("[TB] FAIL stall_done_%0d: got %b want %b", i, cpu_done, exp_done); end
            if (i < 3) begin
                axi_bus.RDATA = 32'h11 + 32'(i);
                axi_bus.RLAST = (i == 2);
            end else begin
                slave_idle();
            end
        end
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0 || cpu_done !== 1'b0) begin failures++; $display("[TB] FAIL stall_tail: got rvalid=%b done=%b want 0/0", cpu_rvalid, cpu_done); end
    endtask

    task automatic test_rvalid_gaps();
        int          pulses = 0;
        int          dones  = 0;
        logic [31:0] got [2];
        got[0] = 32'h0;
        got[1] = 32'h0;
        slave_idle();
        issue_req(32'h0000_3000, 4'd1);
        axi_bus.ARREADY = 1'b1;
        @(negedge clk);
        axi_bus.ARREADY = 1'b0;
        for (int c = 0; c < 9; c++) begin
            axi_bus.RVALID = (c == 2 || c == 5);
            axi_bus.RDATA  = 32'hA000 + 32'(c);
            axi_bus.RLAST  = (c == 5);
            @(negedge clk);
            if (cpu_rvalid === 1'b1) begin
                if (pulses < 2) got[pulses] = cpu_rdata;
                pulses++;
            end
            if (cpu_done === 1'b1) dones++;
        end
        slave_idle();
        checks++; if (pulses != 2) begin failures++; $display("[TB] FAIL gaps_pulse_count: got %0d want 2", pulses); end
        checks++; if (got[0] !== 32'hA002 || got[1] !== 32'hA005) begin failures++; $display("[TB] FAIL gaps_data: got %h,%h want 0000a002,0000a005", got[0], got[1]); end
        checks++; if (dones != 1) begin failures++; $display("[TB] FAIL gaps_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_rlast_rules();
        logic exp_err;
`ifdef AXI_RD_MASTER_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        slave_idle();
        issue_req(32'h0000_4000, 4'd0);
        axi_bus.ARREADY = 1'b1;
        @(negedge clk);
        axi_bus.ARREADY = 1'b0;
        axi_bus.RVALID  = 1'b1;
        axi_bus.RID     = 4'd5;
        axi_bus.RDATA   = 32'hBAD0;
        axi_bus.RLAST   = 1'b1;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0 || cpu_done !== 1'b0 || axi_bus.RREADY !== 1'b1) begin failures++; $display("[TB] FAIL foreign_id: got rvalid=%b done=%b rready=%b want 0/0/1", cpu_rvalid, cpu_done, axi_bus.RREADY); end
        axi_bus.RID   = 4'd0;
        axi_bus.RDATA = 32'h5000;
        axi_bus.RLAST = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5000 || cpu_done !== 1'b0) begin failures++; $display("[TB] FAIL len_reached_no_last: got v=%b d=%h done=%b want 1/00005000/0", cpu_rvalid, cpu_rdata, cpu_done); end
        checks++; if (axi_bus.RREADY !== 1'b1) begin failures++; $display("[TB] FAIL len_reached_waits: got rready=%b want 1", axi_bus.RREADY); end
        axi_bus.RDATA = 32'h5001;
        axi_bus.RLAST = 1'b1;
        @(negedge clk);
        slave_idle();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5001 || cpu_done !== 1'b1) begin failures++; $display("[TB] FAIL late_last: got v=%b d=%h done=%b want 1/00005001/1", cpu_rvalid, cpu_rdata, cpu_done); end
        checks++; if (cpu_err !== exp_err) begin failures++; $display("[TB] FAIL len_err_flag: got %b want %b", cpu_err, exp_err); end
        cpu_err_clr = 1'b1;
        @(negedge clk);
        cpu_err_clr = 1'b0;
        checks++; if (cpu_err !== 1'b0) begin failures++; $display("[TB] FAIL len_err_clear: got %b want 0", cpu_err); end
    endtask

    task automatic test_err();
        logic exp_err;
`ifdef AXI_RD_MASTER_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        slave_idle();
        issue_req(32'h0000_5000, 4'd0);
        axi_bus.ARREADY = 1'b1;
        @(negedge clk);
        axi_bus.ARREADY = 1'b0;
        axi_bus.RVALID  = 1'b1;
        axi_bus.RDATA   = 32'h77;
        axi_bus.RRESP   = 2'b10;
        axi_bus.RLAST   = 1'b1;
        cpu_err_clr     = 1'b1;
        @(negedge clk);
        slave_idle();
        cpu_err_clr = 1'b0;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_done !== 1'b1 || cpu_rdata !== 32'h77) begin failures++; $display("[TB] FAIL err_beat: got v=%b done=%b d=%h want 1/1/00000077", cpu_rvalid, cpu_done, cpu_rdata); end
        checks++; if (cpu_err !== exp_err) begin failures++; $display("[TB] FAIL err_set_wins: got %b want %b", cpu_err, exp_err); end
        repeat (2) @(negedge clk);
        checks++; if (cpu_err !== exp_err) begin failures++; $display("[TB] FAIL err_sticky: got %b want %b", cpu_err, exp_err); end
        cpu_err_clr = 1'b1;
        @(negedge clk);
        cpu_err_clr = 1'b0;
        checks++; if (cpu_err !== 1'b0) begin failures++; $display("[TB] FAIL err_clear: got %b want 0", cpu_err); end
    endtask

    task automatic test_reset_midburst();
        slave_idle();
        issue_req(32'h0000_6000, 4'd3);
        axi_bus.ARREADY = 1'b1;
        @(negedge clk);
        axi_bus.ARREADY = 1'b0;
        axi_bus.RVALID  = 1'b1;
        axi_bus.RDATA   = 32'h60;
        @(negedge clk);
        axi_bus.RDATA = 32'h61;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (axi_bus.ARVALID !== 1'b0 || axi_bus.RREADY !== 1'b0) begin failures++; $display("[TB] FAIL midrst_bus: got arvalid=%b rready=%b want 0/0", axi_bus.ARVALID, axi_bus.RREADY); end
        checks++; if (cpu_done !== 1'b0 || cpu_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_pulses: got done=%b rvalid=%b want 0/0", cpu_done, cpu_rvalid); end
        slave_idle();
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cpu_ready !== 1'b1 || cpu_done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_idle: got ready=%b done=%b want 1/0", cpu_ready, cpu_done); end
        issue_req(32'h0000_7000, 4'd0);
        axi_bus.ARREADY = 1'b1;
        axi_bus.RVALID  = 1'b1;
        axi_bus.RDATA   = 32'h7777;
        axi_bus.RLAST   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        slave_idle();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_done !== 1'b1 || cpu_rdata !== 32'h7777) begin failures++; $display("[TB] FAIL midrst_recover: got v=%b done=%b d=%h want 1/1/00007777", cpu_rvalid, cpu_done, cpu_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        slave_idle();
        axi_bus.ARREADY = 1'b1;
        axi_bus.RVALID  = 1'b1;
        axi_bus.RLAST   = 1'b1;
        axi_bus.RDATA   = 32'h900;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_8000;
        cpu_len  = 4'd0;
        @(negedge clk);
        checks++; if (axi_bus.ARVALID !== 1'b1 || axi_bus.ARADDR !== 32'h0000_8000) begin failures++; $display("[TB] FAIL b2b_first_ar: got v=%b a=%h want 1/00008000", axi_bus.ARVALID, axi_bus.ARADDR); end
        cpu_addr = 32'h0000_8100;
        @(negedge clk);
        @(negedge clk);
        checks++; if (cpu_done !== 1'b1 || cpu_ready !== 1'b0 || axi_bus.ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_cycle: got done=%b ready=%b arvalid=%b want 1/0/0", cpu_done, cpu_ready, axi_bus.ARVALID); end
        @(negedge clk);
        checks++; if (cpu_ready !== 1'b1 || axi_bus.ARVALID !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_again: got ready=%b arvalid=%b want 1/0", cpu_ready, axi_bus.ARVALID); end
        @(negedge clk);
        checks++; if (axi_bus.ARVALID !== 1'b1 || axi_bus.ARADDR !== 32'h0000_8100) begin failures++; $display("[TB] FAIL b2b_second_ar: got v=%b a=%h want 1/00008100", axi_bus.ARVALID, axi_bus.ARADDR); end
        cpu_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (cpu_done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_done: got %b want 1", cpu_done); end
        slave_idle();
        repeat (2) @(negedge clk);
        checks++; if (axi_bus.ARVALID !== 1'b0 || cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_no_extra: got arvalid=%b ready=%b want 0/1", axi_bus.ARVALID, cpu_ready); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_ar_stall();
        test_rvalid_gaps();
        test_rlast_rules();
        test_err();
        test_reset_midburst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_master.md
AXI_RD_MASTER -- requirements
Module: axi_rd_master

Interface
REQ-001 Parameter MASTER_ID, default 4'd0: value driven on ARID for every request.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cpu_req  input  1  request strobe; accepted only when cpu_ready=1.
REQ-005 cpu_addr  input  32  byte start address; bits [1:0] ignored.
REQ-006 cpu_len  input  4  burst length minus 1 (0..15 beats-1).
REQ-007 cpu_ready  output  1  block idle; a request can be accepted.
REQ-008 cpu_rdata  output  32  registered read beat.
REQ-009 cpu_rvalid  output  1  one-cycle pulse per forwarded beat.
REQ-010 cpu_done  output  1  one-cycle pulse coincident with the final cpu_rvalid of a burst.
REQ-011 cpu_err  output  1  sticky error flag; see Configuration.
REQ-012 cpu_err_clr  input  1  clears cpu_err.
REQ-013 ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  output  4/32/4/3/2/1  AXI read-address channel.
REQ-014 ARREADY  input  1  AXI read-address ready.
REQ-015 RID/RDATA/RRESP/RLAST/RVALID  input  4/32/2/1/1  AXI read-data channel.
REQ-016 RREADY  output  1  AXI read-data ready.

Function
REQ-017 FSM states IDLE, ADDR, DATA; reset state IDLE.
REQ-018 IDLE: cpu_ready=1; cpu_req=1 latches cpu_addr (word-aligned) and cpu_len, goes to ADDR.
REQ-019 ADDR: ARVALID=1; ARADDR, ARLEN, ARID=MASTER_ID, ARSIZE=3'b010, ARBURST=2'b01 (INCR) held stable until ARVALID&ARREADY; then DATA.
REQ-020 ARVALID never deasserts before the handshake; ARVALID=0 in IDLE and DATA.
REQ-021 DATA: RREADY=1; each RVALID&RREADY beat is registered: cpu_rdata<=RDATA, cpu_rvalid=1 next cycle.
REQ-022 4-bit beat counter clears on entry to DATA, increments per accepted beat.
REQ-023 Burst ends on the beat with RLAST=1: cpu_done=1 the next cycle with that beat's cpu_rvalid; FSM returns to IDLE.
REQ-024 A beat counter reaching cpu_len without RLAST does not end the burst; block waits for RLAST.
REQ-025 Beats with RID!=MASTER_ID are accepted (RREADY=1) but not forwarded and do not count.
REQ-026 cpu_req while cpu_ready=0 is ignored, including the cycle of cpu_done; earliest next acceptance is the cycle after return to IDLE.
REQ-027 Minimum latency: ARVALID asserts the cycle after cpu_req acceptance; single-beat burst with ARREADY and RVALID immediate gives cpu_done 3 cycles after acceptance.
REQ-028 Outputs otherwise 0: cpu_rvalid, cpu_done, RREADY, ARVALID; AR payload may hold last value.

Reset
REQ-029 rst=1 asynchronously forces IDLE; ARVALID=0, RREADY=0, cpu_rvalid=0, cpu_done=0, cpu_err=0, cpu_rdata=0, ARADDR=0, ARLEN=0, counter=0.
REQ-030 Reset mid-burst abandons the transaction; no cpu_done issued for it.

Configuration
REQ-031 Macro AXI_RD_MASTER_ERR_EN defined: cpu_err set on an accepted beat with RRESP!=2'b00, or RLAST with counter!=cpu_len; held until cpu_err_clr=1 (set wins on the same cycle).
REQ-032 Macro undefined: cpu_err tied to 0, cpu_err_clr ignored, no checking logic.

Structure
REQ-033 Package axi_rd_master_pkg holds the state enum typedef and constants SIZE_WORD=3'b010, BURST_INCR=2'b01, RESP_OKAY=2'b00.
REQ-034 AXI widths come from the shared AXI_define.svh macros.
REQ-035 Sub-module rd_beat_counter holds the beat counter and RLAST/length comparison.

Verification
REQ-036 cpu_req addr=0x0000_1004 len=0, ARREADY=1, RDATA=0xDEADBEEF RLAST=1 -> ARADDR=0x1004, ARLEN=0, cpu_rdata=0xDEADBEEF with cpu_rvalid and cpu_done same cycle.
REQ-037 len=3, ARREADY delayed 5 cycles -> AR payload stable all 5 cycles; 4 beats 0x10..0x13 forwarded in order; cpu_done on 4th only.
REQ-038 RVALID gaps of 2 cycles between beats of len=1 burst -> exactly 2 cpu_rvalid pulses, no duplicates.
REQ-039 rst asserted after 2nd beat of len=3 burst -> ARVALID/RREADY/cpu_done low immediately; new request after reset completes normally.
REQ-040 ERR_EN: RRESP=2'b10 on beat 0 -> cpu_err=1 until cpu_err_clr; without macro cpu_err stays 0.
REQ-041 cpu_req held high through whole burst -> exactly one new request accepted, the cycle after return to IDLE.
